// File: rtl/pc_sequencer.sv
// Fetch-stage program counter sequencer: issues instruction fetches, follows
// jump/branch redirects (squashing in-flight fetches) and honours pipeline stalls.
module pc_sequencer #(
   parameter logic [7:0] RESET_PC = 8'h00
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       stall,
   input  logic       jump,
   input  logic [7:0] jump_target,
   input  logic       branch_taken,
   input  logic [7:0] branch_target,
   input  logic [7:0] pc_plus4,
   input  logic       imem_ack,
   output logic [7:0] pc_out,
   output logic       imem_req,
   output logic       fetch_valid,
   output logic [7:0] fetch_pc
);

   typedef enum logic [1:0] {
      IDLE,
      REQ,
      STALL
   } state_t;

   state_t     state;
   logic       idle_done;
   logic       pending;
   logic       squash;
   logic [7:0] pend_target;

   logic       redirect;
   logic [7:0] redirect_target;

   // Jump outranks a simultaneous branch.
   assign redirect        = jump | branch_taken;
   assign redirect_target = jump ? jump_target : branch_target;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         idle_done   <= 1'b0;
         pending     <= 1'b0;
         squash      <= 1'b0;
         pend_target <= 8'h00;
         pc_out      <= RESET_PC;
         imem_req    <= 1'b0;
         fetch_valid <= 1'b0;
         fetch_pc    <= 8'h00;
      end else begin
         fetch_valid <= 1'b0;
         case (state)
            IDLE: begin
               if (redirect)
                  pc_out <= redirect_target;
               // One full idle cycle is spent before the first request goes out.
               if (idle_done) begin
                  state    <= REQ;
                  imem_req <= 1'b1;
               end else begin
                  idle_done <= 1'b1;
               end
            end

            REQ: begin
               if (imem_ack) begin
                  if (pending)
                     pc_out <= pend_target;
                  else if (redirect)
                     pc_out <= redirect_target;
                  else
                     pc_out <= pc_plus4;
                  if (!(squash || redirect)) begin
                     fetch_valid <= 1'b1;
                     fetch_pc    <= pc_out;
                  end
                  pending <= 1'b0;
                  squash  <= 1'b0;
                  if (stall) begin
                     state    <= STALL;
                     imem_req <= 1'b0;
                  end
               end else if (redirect) begin
                  // The address is already on the bus, so remember where to go next.
                  pending     <= 1'b1;
                  squash      <= 1'b1;
                  pend_target <= redirect_target;
               end
            end

            STALL: begin
               if (redirect)
                  pc_out <= redirect_target;
               if (!stall) begin
                  state    <= REQ;
                  imem_req <= 1'b1;
               end
            end

            default: begin
               state    <= IDLE;
               imem_req <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed table-driven bench for pc_sequencer with an external +4 adder model
// and hand-written reset sequences.
module tb_pc_sequencer;

   logic       clk;
   logic       rst_n;
   logic       stall;
   logic       jump;
   logic [7:0] jump_target;
   logic       branch_taken;
   logic [7:0] branch_target;
   logic [7:0] pc_plus4;
   logic       imem_ack;
   logic [7:0] pc_out;
   logic       imem_req;
   logic       fetch_valid;
   logic [7:0] fetch_pc;

   int errors = 0;
   int checks = 0;

   pc_sequencer #(.RESET_PC(8'h00)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .stall         (stall),
      .jump          (jump),
      .jump_target   (jump_target),
      .branch_taken  (branch_taken),
      .branch_target (branch_target),
      .pc_plus4      (pc_plus4),
      .imem_ack      (imem_ack),
      .pc_out        (pc_out),
      .imem_req      (imem_req),
      .fetch_valid   (fetch_valid),
      .fetch_pc      (fetch_pc)
   );

   // External sequential-PC adder.
   assign pc_plus4 = pc_out + 8'h04;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic       stall;
      logic       jump;
      logic [7:0] jt;
      logic       br;
      logic [7:0] bt;
      logic       ack;
      logic [7:0] exp_pc;
      logic       exp_req;
      logic       exp_fv;
      logic [7:0] exp_fpc;
   } vec_t;

   localparam int NVEC = 25;
   vec_t vecs[NVEC];

   function automatic vec_t make_vec(logic st, logic j, logic [7:0] jt, logic b,
                                     logic [7:0] bt, logic a, logic [7:0] pc,
                                     logic rq, logic fv, logic [7:0] fpc);
      vec_t v;
      v.stall = st; v.jump = j; v.jt = jt; v.br = b; v.bt = bt; v.ack = a;
      v.exp_pc = pc; v.exp_req = rq; v.exp_fv = fv; v.exp_fpc = fpc;
      return v;
   endfunction

   task automatic check_output(string name, logic [7:0] act, logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic apply_stimulus(vec_t v);
      stall         = v.stall;
      jump          = v.jump;
      jump_target   = v.jt;
      branch_taken  = v.br;
      branch_target = v.bt;
      imem_ack      = v.ack;
   endtask

   task automatic check_all(string tag, logic [7:0] pc, logic rq, logic fv, logic [7:0] fpc);
      check_output({tag, " pc_out"}, pc_out, pc);
      check_output({tag, " imem_req"}, {7'd0, imem_req}, {7'd0, rq});
      check_output({tag, " fetch_valid"}, {7'd0, fetch_valid}, {7'd0, fv});
      if (fv)
         check_output({tag, " fetch_pc"}, fetch_pc, fpc);
   endtask

   initial begin
      //                   st  j  jt     b  bt     ack pc     rq fv fpc
      vecs[0]  = make_vec(0, 0, 8'h00, 0, 8'h00, 1, 8'h00, 0, 0, 8'h00);
      vecs[1]  = make_vec(0, 0, 8'h00, 0, 8'h00, 1, 8'h00, 1, 0, 8'h00);
      vecs[2]  = make_vec(0, 0, 8'h00, 0, 8'h00, 1, 8'h04, 1, 1, 8'h00);
      vecs[3]  = make_vec(0, 0, 8'h00, 0, 8'h00, 1, 8'h08, 1, 1, 8'h04);
      vecs[4]  = make_vec(1, 0, 8'h00, 0, 8'h00, 1, 8'h0C, 0, 1, 8'h08);
      vecs[5]  = make_vec(1, 0, 8'h00, 0, 8'h00, 0, 8'h0C, 0, 0, 8'h00);
      vecs[6]  = make_vec(0, 0, 8'h00, 0, 8'h00, 0, 8'h0C, 1, 0, 8'h00);
      vecs[7]  = make_vec(0, 0, 8'h00, 0, 8'h00, 1, 8'h10, 1, 1, 8'h0C);
      vecs[8]  = make_vec(0, 0, 8'h00, 0, 8'h00, 0, 8'h10, 1, 0, 8'h00);
      vecs[9]  = make_vec(0, 0, 8'h00, 1, 8'h40, 0, 8'h10, 1, 0, 8'h00);
      vecs[10] = make_vec(0, 0, 8'h00, 0, 8'h00, 0, 8'h10, 1, 0, 8'h00);
      vecs[11] = make_vec(0, 0, 8'h00, 0, 8'h00, 1, 8'h40, 1, 0, 8'h00);
      vecs[12] = make_vec(0, 1, 8'h80, 1, 8'h20, 1, 8'h80, 1, 0, 8'h00);
      vecs[13] = make_vec(0, 1, 8'hA0, 0, 8'h00, 0, 8'h80, 1, 0, 8'h00);
      vecs[14] = make_vec(0, 0, 8'h00, 1, 8'hB0, 0, 8'h80, 1, 0, 8'h00);
      vecs[15] = make_vec(0, 1, 8'hC0, 0, 8'h00, 1, 8'hB0, 1, 0, 8'h00);
      vecs[16] = make_vec(0, 0, 8'h00, 0, 8'h00, 1, 8'hB4, 1, 1, 8'hB0);
      vecs[17] = make_vec(1, 0, 8'h00, 0, 8'h00, 0, 8'hB4, 1, 0, 8'h00);
      vecs[18] = make_vec(1, 0, 8'h00, 0, 8'h00, 1, 8'hB8, 0, 1, 8'hB4);
      vecs[19] = make_vec(1, 1, 8'hFC, 0, 8'h00, 0, 8'hFC, 0, 0, 8'h00);
      vecs[20] = make_vec(0, 0, 8'h00, 0, 8'h00, 0, 8'hFC, 1, 0, 8'h00);
      vecs[21] = make_vec(0, 0, 8'h00, 0, 8'h00, 1, 8'h00, 1, 1, 8'hFC);
      vecs[22] = make_vec(0, 0, 8'h00, 0, 8'h00, 0, 8'h00, 1, 0, 8'h00);
      vecs[23] = make_vec(0, 0, 8'h00, 0, 8'h00, 1, 8'h04, 1, 1, 8'h00);
      vecs[24] = make_vec(0, 0, 8'h00, 0, 8'h00, 0, 8'h04, 1, 0, 8'h00);

      rst_n = 1'b0;
      apply_stimulus(make_vec(0, 0, 8'h00, 0, 8'h00, 0, 8'h00, 0, 0, 8'h00));
      #2;
      check_all("reset", 8'h00, 1'b0, 1'b0, 8'h00);
      check_output("reset fetch_pc", fetch_pc, 8'h00);

      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;

      for (int i = 0; i < NVEC; i++) begin
         apply_stimulus(vecs[i]);
         @(posedge clk);
         #1;
         check_all($sformatf("v%0d", i), vecs[i].exp_pc, vecs[i].exp_req,
                   vecs[i].exp_fv, vecs[i].exp_fpc);
      end

      // Reset mid-request must drop the request at once and abandon it.
      rst_n = 1'b0;
      #1;
      check_all("midreset", 8'h00, 1'b0, 1'b0, 8'h00);
      check_output("midreset fetch_pc", fetch_pc, 8'h00);

      imem_ack    = 1'b1;
      jump        = 1'b1;
      jump_target = 8'h50;
      @(posedge clk);
      #1 rst_n = 1'b1;
      @(posedge clk);
      #1;
      check_all("idle_jump", 8'h50, 1'b0, 1'b0, 8'h00);
      jump = 1'b0;
      @(posedge clk);
      #1;
      check_all("first_req", 8'h50, 1'b1, 1'b0, 8'h00);
      @(posedge clk);
      #1;
      check_all("first_ack", 8'h54, 1'b1, 1'b1, 8'h50);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
